mem_stage_sequencer: RTL and testbench
======================================

# mem_stage_sequencer

Top-level scheduler for the shared 16-bit word data memory. It runs up to NUM_STAGES processing sub-blocks in fixed order, one at a time. Each sub-block uses the en/start/done protocol with a single-port memory interface (address, wr_en, data_out). The sequencer owns the memory port and muxes it to the active stage. It also enforces a per-stage watchdog and reports overall completion or error to the controller above it.

## Interface
- NUM_STAGES, 4: number of client sub-blocks; index 0 runs first.
- WORD_WIDTH, 16: memory address/data width.
- TIMEOUT, 4096: maximum WAIT cycles allowed per stage before abort; must be ≥ 1.
- clock  in  1  system clock; everything on the rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  request to start a sequence; sampled only in IDLE.
- stage_mask  in  NUM_STAGES  bit s set = run stage s; captured on run acceptance.
- client_en  out  NUM_STAGES  one-cycle enable pulse to stage s (re-arms the client from idle).
- client_start  out  NUM_STAGES  one-cycle start pulse to stage s.
- client_done  in  NUM_STAGES  level done from each client; held high until that client's next en.
- client_address  in  NUM_STAGES*WORD_WIDTH  per-client address, stage s at bits [s*WORD_WIDTH +: WORD_WIDTH].
- client_wr_en  in  NUM_STAGES  per-client write enable.
- client_data_out  in  NUM_STAGES*WORD_WIDTH  per-client write data.
- mem_address  out  WORD_WIDTH  to memory.
- mem_wr_en  out  1  to memory.
- mem_data_out  out  WORD_WIDTH  to memory.
- Memory read data is broadcast to all clients outside this block; it does not pass through here.
- busy  out  1  high whenever state ≠ IDLE.
- seq_done  out  1  level; set at sequence end (normal or abort), cleared on the next accepted run.
- error  out  1  level; set on watchdog abort, cleared on the next accepted run.
- err_stage  out  clog2(NUM_STAGES)  index of the stage that timed out; valid while error=1.
- cur_stage  out  clog2(NUM_STAGES)  index of the active stage.

## Operation
- States: IDLE, EN, START, WAIT, NEXT. All control outputs decode from registered state (Moore).
- Reset values: state=IDLE; client_en=0; client_start=0; mem_address=0; mem_wr_en=0; mem_data_out=0; busy=0; seq_done=0; error=0; err_stage=0; cur_stage=0; watchdog=0.
- IDLE, run=1: capture stage_mask; clear seq_done and error.
  - If the mask is non-zero: cur_stage = lowest set bit; go to EN.
  - If the mask is zero: set seq_done; stay in IDLE.
- run=0 in IDLE: hold. run while busy is ignored.
- EN: client_en[cur_stage]=1 for exactly one cycle; go to START.
- START: client_start[cur_stage]=1 for exactly one cycle; clear watchdog; go to WAIT.
- WAIT: client_done[cur_stage] is sampled here only. Stale done from a previous run is cleared by the EN pulse and must never be observed.
  - done=1: go to NEXT.
  - Otherwise watchdog increments. When watchdog reaches TIMEOUT-1 with done still 0: set error, load err_stage=cur_stage, set seq_done, go to IDLE.
  - done and timeout in the same cycle: done wins.
- NEXT: search the captured mask above cur_stage.
  - Found: cur_stage = that index; go to EN.
  - None: set seq_done; go to IDLE. cur_stage holds the last stage run.
- Memory mux: in EN, START and WAIT, mem_* = client_*[cur_stage] combinationally. In IDLE and NEXT, mem_address=0, mem_wr_en=0, mem_data_out=0.
- Non-active clients' wr_en is ignored entirely; it must never reach memory.
- After a timeout abort, the stuck client is not recovered; the system requires rst.
- rst mid-sequence: all outputs return to reset values on the next edge, with no further en/start pulses.

## Timing
- run sampled high at edge of cycle T:
  - EN in cycle T+1 (client_en pulse).
  - START in cycle T+2 (client_start pulse).
  - WAIT from cycle T+3.
- client_done high in WAIT cycle W:
  - NEXT in W+1.
  - Next stage's EN in W+2, or IDLE with seq_done=1 in W+2.
- Per-stage overhead: 3 cycles (EN, START, NEXT) plus the client's own run time.
- Zero-latency memory mux: client address/wr_en/data pass through in the same cycle.
- Abort: error and seq_done are visible the cycle after the TIMEOUT-th WAIT cycle; busy=0 in that same cycle.

## Test plan
- Mask 4'b1111; client BFMs assert done 10 cycles after start. Expect:
  - en/start pulses for stages 0,1,2,3 in order, each single-cycle;
  - seq_done=1 at T+4*(3+10)+… with the exact cycle computed from the Timing rules;
  - error=0.
- Mask 4'b1010: only stages 1 and 3 are pulsed. While stage 1 is active, client 0 drives wr_en=1 at address 0x068A; mem_wr_en must stay 0.
- Stale done: all client_done held high before run. Each stage waits for done to drop and rise again; no stage is skipped.
- TIMEOUT=16; client 2 never asserts done. Expect:
  - error=1, err_stage=2, seq_done=1, busy=0 exactly 16 WAIT cycles after start;
  - stage 3 is never enabled.
- Mask 4'b0000 with run: seq_done=1 on the next cycle; no en/start pulses; busy stays 0. A second run with mask 4'b0001 clears seq_done and runs stage 0.
- rst asserted during stage 1 WAIT: next cycle all outputs are 0 and state is IDLE. run afterwards restarts cleanly from stage 0.

Source files
------------

// File: rtl/mem_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_sequencer
// Description : Runs up to NUM_STAGES client sub-blocks in fixed order through
//               an en/start/done handshake, muxes the shared memory port to the
//               active client and aborts a stage that exceeds its watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int WORD_WIDTH  = 16,
    parameter int TIMEOUT     = 4096,
    localparam int c_STAGE_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                             clock,
    input  logic                             rst,
    input  logic                             run,
    input  logic [NUM_STAGES-1:0]            stage_mask,
    output logic [NUM_STAGES-1:0]            client_en,
    output logic [NUM_STAGES-1:0]            client_start,
    input  logic [NUM_STAGES-1:0]            client_done,
    input  logic [NUM_STAGES*WORD_WIDTH-1:0] client_address,
    input  logic [NUM_STAGES-1:0]            client_wr_en,
    input  logic [NUM_STAGES*WORD_WIDTH-1:0] client_data_out,
    output logic [WORD_WIDTH-1:0]            mem_address,
    output logic                             mem_wr_en,
    output logic [WORD_WIDTH-1:0]            mem_data_out,
    output logic                             busy,
    output logic                             seq_done,
    output logic                             error,
    output logic [c_STAGE_W-1:0]             err_stage,
    output logic [c_STAGE_W-1:0]             cur_stage
);

    localparam int              c_WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EN    = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_NEXT  = 3'd4
    } state_t;

    state_t                  r_state;
    logic [NUM_STAGES-1:0]   r_mask;
    logic [c_STAGE_W-1:0]    r_cur_stage;
    logic [c_STAGE_W-1:0]    r_err_stage;
    logic [c_WD_W-1:0]       r_watchdog;
    logic [NUM_STAGES-1:0]   r_client_en;
    logic [NUM_STAGES-1:0]   r_client_start;
    logic                    r_busy;
    logic                    r_seq_done;
    logic                    r_error;

    logic                    w_first_found;
    logic [c_STAGE_W-1:0]    w_first_idx;
    logic                    w_next_found;
    logic [c_STAGE_W-1:0]    w_next_idx;
    logic                    w_active;
    logic [WORD_WIDTH-1:0]   w_addr_arr [NUM_STAGES];
    logic [WORD_WIDTH-1:0]   w_data_arr [NUM_STAGES];

    genvar g;
    generate
        for (g = 0; g < NUM_STAGES; g++) begin : g_unpack
            assign w_addr_arr[g] = client_address[g*WORD_WIDTH +: WORD_WIDTH];
            assign w_data_arr[g] = client_data_out[g*WORD_WIDTH +: WORD_WIDTH];
        end
    endgenerate

    // Descending scan so the last hit is the lowest qualifying index.
    always_comb begin
        w_first_found = 1'b0;
        w_first_idx   = '0;
        w_next_found  = 1'b0;
        w_next_idx    = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (stage_mask[i]) begin
                w_first_found = 1'b1;
                w_first_idx   = c_STAGE_W'(i);
            end
            if (r_mask[i] && (c_STAGE_W'(i) > r_cur_stage)) begin
                w_next_found = 1'b1;
                w_next_idx   = c_STAGE_W'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_mask         <= '0;
            r_cur_stage    <= '0;
            r_err_stage    <= '0;
            r_watchdog     <= '0;
            r_client_en    <= '0;
            r_client_start <= '0;
            r_busy         <= 1'b0;
            r_seq_done     <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_client_en    <= '0;
            r_client_start <= '0;
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_mask  <= stage_mask;
                        r_error <= 1'b0;
                        if (w_first_found) begin
                            r_cur_stage <= w_first_idx;
                            r_client_en <= NUM_STAGES'(1) << w_first_idx;
                            r_busy      <= 1'b1;
                            r_seq_done  <= 1'b0;
                            r_state     <= S_EN;
                        end else begin
                            r_seq_done  <= 1'b1;
                        end
                    end
                end
                S_EN: begin
                    r_client_start <= NUM_STAGES'(1) << r_cur_stage;
                    r_state        <= S_START;
                end
                S_START: begin
                    r_watchdog <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    // Done takes priority over an expiring watchdog.
                    if (client_done[r_cur_stage]) begin
                        r_state <= S_NEXT;
                    end else if (r_watchdog == c_WD_LAST) begin
                        r_error     <= 1'b1;
                        r_err_stage <= r_cur_stage;
                        r_seq_done  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_watchdog <= r_watchdog + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (w_next_found) begin
                        r_cur_stage <= w_next_idx;
                        r_client_en <= NUM_STAGES'(1) << w_next_idx;
                        r_state     <= S_EN;
                    end else begin
                        r_seq_done <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Only the active client ever reaches the memory port.
    assign w_active     = (r_state == S_EN) || (r_state == S_START) || (r_state == S_WAIT);
    assign mem_address  = w_active ? w_addr_arr[r_cur_stage] : '0;
    assign mem_data_out = w_active ? w_data_arr[r_cur_stage] : '0;
    assign mem_wr_en    = w_active & client_wr_en[r_cur_stage];

    assign client_en    = r_client_en;
    assign client_start = r_client_start;
    assign busy         = r_busy;
    assign seq_done     = r_seq_done;
    assign error        = r_error;
    assign err_stage    = r_err_stage;
    assign cur_stage    = r_cur_stage;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_sequencer
// Description : Self-checking bench: directed vector table plus randomized
//               sequences against a schedule-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_sequencer;

    localparam int NS   = 4;
    localparam int WW   = 16;
    localparam int TO   = 16;
    localparam int SW   = 2;
    localparam int MAXL = 256;
    localparam int NV   = 10;

    logic              clock = 1'b0;
    logic              rst;
    logic              run;
    logic [NS-1:0]     stage_mask;
    logic [NS-1:0]     client_en;
    logic [NS-1:0]     client_start;
    logic [NS-1:0]     client_done;
    logic [NS*WW-1:0]  client_address;
    logic [NS-1:0]     client_wr_en;
    logic [NS*WW-1:0]  client_data_out;
    logic [WW-1:0]     mem_address;
    logic              mem_wr_en;
    logic [WW-1:0]     mem_data_out;
    logic              busy;
    logic              seq_done;
    logic              error;
    logic [SW-1:0]     err_stage;
    logic [SW-1:0]     cur_stage;

    always #5 clock = ~clock;

    mem_stage_sequencer #(
        .NUM_STAGES (NS),
        .WORD_WIDTH (WW),
        .TIMEOUT    (TO)
    ) dut (
        .clock           (clock),
        .rst             (rst),
        .run             (run),
        .stage_mask      (stage_mask),
        .client_en       (client_en),
        .client_start    (client_start),
        .client_done     (client_done),
        .client_address  (client_address),
        .client_wr_en    (client_wr_en),
        .client_data_out (client_data_out),
        .mem_address     (mem_address),
        .mem_wr_en       (mem_wr_en),
        .mem_data_out    (mem_data_out),
        .busy            (busy),
        .seq_done        (seq_done),
        .error           (error),
        .err_stage       (err_stage),
        .cur_stage       (cur_stage)
    );

    typedef struct {
        logic [NS-1:0] mask;
        int d0, d1, d2, d3;      // client done latency after start; 0 = never
        bit stale, rst_before;
        int rst_at;              // cycle offset to assert rst mid-run; 0 = none
        int done_off, err, es, cur, en_cnt, wr_cnt;
    } vec_t;

    vec_t tbl [NV];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Client BFM state
    int            delay [NS];
    bit            bfm_armed [NS];
    int            bfm_start [NS];
    logic [NS-1:0] bfm_held;

    // Reference schedule
    int m_en [MAXL];
    int m_start [MAXL];
    int m_act [MAXL];
    int m_cur [MAXL];
    int m_es [MAXL];
    bit m_busy [MAXL];
    bit m_sd [MAXL];
    bit m_err [MAXL];
    int m_len;
    int fin_cur, fin_es;
    bit fin_err;
    int prev_cur, prev_es;
    bit prev_sd, prev_err;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Schedule from the timing rules: each stage spans EN, START, D WAIT
    // cycles and NEXT; a stage whose client is slower than TO aborts.
    task automatic build_model(input logic [NS-1:0] mask);
        int t;
        bit ab;
        t = 1; ab = 1'b0;
        fin_cur = prev_cur; fin_es = prev_es; fin_err = 1'b0;
        for (int k = 0; k < MAXL; k++) begin
            m_en[k] = -1; m_start[k] = -1; m_act[k] = -1; m_cur[k] = 0;
            m_es[k] = 0; m_busy[k] = 1'b0; m_sd[k] = 1'b0; m_err[k] = 1'b0;
        end
        for (int s = 0; s < NS; s++) begin
            if (mask[s] && !ab) begin
                m_en[t] = s;
                m_start[t+1] = s;
                if (delay[s] == 0 || delay[s] > TO) begin
                    for (int k = t; k <= t + 1 + TO; k++) begin
                        m_busy[k] = 1'b1; m_act[k] = s; m_cur[k] = s;
                    end
                    ab = 1'b1; fin_err = 1'b1; fin_es = s; fin_cur = s;
                    t = t + TO + 2;
                end else begin
                    for (int k = t; k <= t + 1 + delay[s]; k++) begin
                        m_busy[k] = 1'b1; m_act[k] = s; m_cur[k] = s;
                    end
                    m_busy[t + delay[s] + 2] = 1'b1;
                    m_cur[t + delay[s] + 2]  = s;
                    fin_cur = s;
                    t = t + delay[s] + 3;
                end
            end
        end
        m_len = t + 3;
        for (int k = t; k < m_len; k++) begin
            m_sd[k] = 1'b1; m_err[k] = fin_err; m_es[k] = fin_es; m_cur[k] = fin_cur;
        end
        m_sd[0] = prev_sd; m_err[0] = prev_err; m_es[0] = prev_es; m_cur[0] = prev_cur;
    endtask

    task automatic drive(input int k, input bit rnd);
        for (int s = 0; s < NS; s++) begin
            if (bfm_armed[s] && delay[s] != 0 && cyc >= bfm_start[s] + delay[s])
                bfm_held[s] = 1'b1;
        end
        client_done = bfm_held;
        if (rnd) begin
            client_address  = {$urandom, $urandom};
            client_data_out = {$urandom, $urandom};
            client_wr_en    = 4'($urandom);
            run = (k == 0) || (m_busy[k] && $urandom_range(0, 1) == 1);
        end else begin
            for (int s = 0; s < NS; s++) begin
                client_address[s*WW +: WW]  = (s == 0) ? 16'h068A : 16'(32'h1000 * s + k);
                client_data_out[s*WW +: WW] = 16'(32'hA000 + s);
            end
            client_wr_en = 4'b0001;
            run = (k == 0);
        end
    endtask

    task automatic check_cycle(input int k);
        chk("client_en", int'(client_en), (m_en[k] >= 0) ? (1 << m_en[k]) : 0);
        chk("client_start", int'(client_start), (m_start[k] >= 0) ? (1 << m_start[k]) : 0);
        chk("busy", int'(busy), int'(m_busy[k]));
        chk("seq_done", int'(seq_done), int'(m_sd[k]));
        chk("error", int'(error), int'(m_err[k]));
        chk("cur_stage", int'(cur_stage), m_cur[k]);
        if (m_err[k]) chk("err_stage", int'(err_stage), m_es[k]);
        if (m_act[k] >= 0) begin
            chk("mem_address", int'(mem_address), int'(client_address[m_act[k]*WW +: WW]));
            chk("mem_data_out", int'(mem_data_out), int'(client_data_out[m_act[k]*WW +: WW]));
            chk("mem_wr_en", int'(mem_wr_en), int'(client_wr_en[m_act[k]]));
        end else begin
            chk("mem_idle", int'({mem_address, mem_data_out, mem_wr_en}), 0);
        end
    endtask

    task automatic bfm_update();
        for (int s = 0; s < NS; s++) begin
            if (client_en[s]) begin
                bfm_held[s]  = 1'b0;
                bfm_armed[s] = 1'b0;
            end
            if (client_start[s]) begin
                bfm_armed[s] = 1'b1;
                bfm_start[s] = cyc;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_en_start"}, int'({client_en, client_start}), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done_err"}, int'({seq_done, error}), 0);
        chk({tag, "_stages"}, int'({err_stage, cur_stage}), 0);
        chk({tag, "_mem"}, int'({mem_address, mem_data_out, mem_wr_en}), 0);
        prev_cur = 0; prev_es = 0; prev_sd = 1'b0; prev_err = 1'b0;
    endtask

    task automatic do_reset(input bit stale);
        rst = 1'b1;
        run = 1'b0;
        next_cycle();
        rst = 1'b0;
        check_zero("reset");
        for (int s = 0; s < NS; s++) bfm_armed[s] = 1'b0;
        bfm_held = stale ? '1 : '0;
    endtask

    task automatic run_seq(input logic [NS-1:0] mask, input bit rnd, input int rst_at,
                           output int done_off, output int en_cnt, output int wr_cnt);
        build_model(mask);
        stage_mask = mask;
        done_off = -1; en_cnt = 0; wr_cnt = 0;
        for (int k = 0; k < m_len; k++) begin
            drive(k, rnd);
            if (rst_at != 0 && k == rst_at) rst = 1'b1;
            #1;
            check_cycle(k);
            if (k > 0 && done_off < 0 && seq_done) done_off = k;
            if (|client_en) en_cnt++;
            if (mem_wr_en) wr_cnt++;
            bfm_update();
            next_cycle();
            if (k == 0 && rnd) stage_mask = 4'($urandom);
            if (rst_at != 0 && k == rst_at) break;
        end
        run = 1'b0;
        if (rst_at != 0) begin
            rst = 1'b0;
            check_zero("midrst");
        end else begin
            prev_cur = fin_cur; prev_es = fin_es; prev_sd = 1'b1; prev_err = fin_err;
        end
    endtask

    initial begin
        int done_off, en_cnt, wr_cnt;
        rst = 1'b1; run = 1'b0; stage_mask = '0;
        client_done = '0; client_wr_en = '0; client_address = '0; client_data_out = '0;
        bfm_held = '0;
        for (int s = 0; s < NS; s++) begin
            delay[s] = 0; bfm_armed[s] = 1'b0; bfm_start[s] = 0;
        end
        prev_cur = 0; prev_es = 0; prev_sd = 1'b0; prev_err = 1'b0;

        //            mask     d0  d1  d2  d3 stl rb rst_at off err es cur en wr
        tbl[0] = '{4'b1111, 10, 10, 10, 10, 0, 1, 0,  53, 0, 0, 3, 4, 12};
        tbl[1] = '{4'b1010, 10, 10, 10, 10, 0, 0, 0,  27, 0, 0, 3, 2, 0};
        tbl[2] = '{4'b1111,  5,  5,  5,  5, 1, 1, 0,  33, 0, 0, 3, 4, 7};
        tbl[3] = '{4'b1111, 10, 10,  0, 10, 0, 0, 0,  45, 1, 2, 2, 3, 12};
        tbl[4] = '{4'b0000, 10, 10, 10, 10, 0, 1, 0,   1, 0, 0, 0, 0, 0};
        tbl[5] = '{4'b0001,  3,  3,  3,  3, 0, 0, 0,   7, 0, 0, 0, 1, 5};
        tbl[6] = '{4'b0001, 16,  3,  3,  3, 0, 0, 0,  20, 0, 0, 0, 1, 18};
        tbl[7] = '{4'b0001, 17,  3,  3,  3, 0, 0, 0,  19, 1, 0, 0, 1, 18};
        tbl[8] = '{4'b1111, 10, 10, 10, 10, 0, 1, 18, -1, 0, 0, 0, 2, 12};
        tbl[9] = '{4'b1111,  2,  2,  2,  2, 0, 0, 0,  21, 0, 0, 3, 4, 4};

        @(posedge clock);
        #1;
        cyc = 1;
        do_reset(1'b0);

        for (int i = 0; i < NV; i++) begin
            if (tbl[i].rst_before) do_reset(tbl[i].stale);
            delay[0] = tbl[i].d0; delay[1] = tbl[i].d1;
            delay[2] = tbl[i].d2; delay[3] = tbl[i].d3;
            run_seq(tbl[i].mask, 1'b0, tbl[i].rst_at, done_off, en_cnt, wr_cnt);
            chk($sformatf("vec%0d_done_cycle", i), done_off, tbl[i].done_off);
            chk($sformatf("vec%0d_error", i), int'(error), tbl[i].err);
            if (tbl[i].err != 0) chk($sformatf("vec%0d_err_stage", i), int'(err_stage), tbl[i].es);
            chk($sformatf("vec%0d_cur_stage", i), int'(cur_stage), tbl[i].cur);
            chk($sformatf("vec%0d_en_count", i), en_cnt, tbl[i].en_cnt);
            chk($sformatf("vec%0d_wr_cycles", i), wr_cnt, tbl[i].wr_cnt);
            chk($sformatf("vec%0d_busy_end", i), int'(busy), 0);
        end

        for (int r = 0; r < 25; r++) begin
            if (prev_err) do_reset(1'($urandom));
            for (int s = 0; s < NS; s++) delay[s] = $urandom_range(0, 20);
            run_seq(4'($urandom), 1'b1, 0, done_off, en_cnt, wr_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
